led_control_multi: RTL and testbench

LED_CONTROL_MULTI -- requirements
Module: led_control_multi

---
 rtl/led_control_multi.sv | 128 ++++++++++++
 tb/tb_led_control_multi.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_control_multi.sv
// Multi-channel LED driver: off/on/slow/fast/vary flash and event pulse-stretch.
// One shared 10 ms prescaler keeps every flashing channel phase-aligned.
module led_control_multi #(
   parameter int CLOCK_SPEED   = 25000000,
   parameter int CHANNELS      = 4,
   parameter bit ACTIVE_LOW    = 1'b1,
   parameter int STRETCH_TICKS = 10
) (
   input  logic                    i_clock,
   input  logic                    i_reset_n,
   input  logic [3*CHANNELS-1:0]   i_mode,
   input  logic [CHANNELS-1:0]     i_event,
   output logic [CHANNELS-1:0]     o_led
);

   localparam int TICK_DIV = CLOCK_SPEED / 100;
   localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [PW-1:0] PRE_TOP = PW'(TICK_DIV - 1);
   localparam logic [5:0]    STRETCH = 6'(STRETCH_TICKS);

   localparam logic [2:0] M_ON    = 3'd1;
   localparam logic [2:0] M_SLOW  = 3'd2;
   localparam logic [2:0] M_FAST  = 3'd3;
   localparam logic [2:0] M_VARY  = 3'd4;
   localparam logic [2:0] M_PULSE = 3'd5;

   logic [PW-1:0] r_pre;
   logic          w_tick;

   assign w_tick = (r_pre == PRE_TOP);

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_pre <= '0;
      end else if (w_tick) begin
         r_pre <= '0;
      end else begin
         r_pre <= r_pre + 1'b1;
      end
   end

   genvar g;
   for (g = 0; g < CHANNELS; g++) begin : g_ch
      logic [2:0] r_mode_q;
      logic       r_lit;
      logic [5:0] r_cnt;
      logic [1:0] r_swap;
      logic [5:0] r_stretch;

      logic [2:0] w_m;
      logic       w_chg;
      logic [5:0] w_half;
      logic       w_lit_n;
      logic [5:0] w_cnt_n;
      logic [1:0] w_swap_n;
      logic [5:0] w_str_n;

      assign w_m   = i_mode[3*g +: 3];
      assign w_chg = (w_m != r_mode_q);

      always_comb begin
         w_half   = ((w_m == M_SLOW) || ((w_m == M_VARY) && !r_swap[1]))
                    ? 6'd50 : 6'd10;
         w_lit_n  = 1'b0;
         w_cnt_n  = '0;
         w_swap_n = '0;
         w_str_n  = '0;
         // A mode change restarts the channel and swallows any coincident tick
         if (w_chg) begin
            w_lit_n = (w_m == M_ON);
            if ((w_m == M_PULSE) && i_event[g]) begin
               w_lit_n = 1'b1;
               w_str_n = STRETCH;
            end
         end else begin
            case (w_m)
               M_ON: w_lit_n = 1'b1;
               M_SLOW, M_FAST, M_VARY: begin
                  w_lit_n  = r_lit;
                  w_cnt_n  = r_cnt;
                  w_swap_n = r_swap;
                  if (w_tick) begin
                     if (r_cnt == w_half - 6'd1) begin
                        w_lit_n = ~r_lit;
                        w_cnt_n = '0;
                        if (w_m == M_VARY) w_swap_n = r_swap + 2'd1;
                     end else begin
                        w_cnt_n = r_cnt + 6'd1;
                     end
                  end
               end
               M_PULSE: begin
                  w_lit_n = r_lit;
                  w_str_n = r_stretch;
                  if (i_event[g]) begin
                     w_lit_n = 1'b1;
                     w_str_n = STRETCH;
                  end else if (w_tick && (r_stretch != 6'd0)) begin
                     w_str_n = r_stretch - 6'd1;
                     if (r_stretch == 6'd1) w_lit_n = 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end

      always_ff @(posedge i_clock or negedge i_reset_n) begin
         if (!i_reset_n) begin
            r_mode_q  <= '0;
            r_lit     <= 1'b0;
            r_cnt     <= '0;
            r_swap    <= '0;
            r_stretch <= '0;
         end else begin
            r_mode_q  <= w_m;
            r_lit     <= w_lit_n;
            r_cnt     <= w_cnt_n;
            r_swap    <= w_swap_n;
            r_stretch <= w_str_n;
         end
      end

      assign o_led[g] = r_lit ^ ACTIVE_LOW;
   end

endmodule

// File: tb/tb_led_control_multi.sv
// Directed bench for led_control_multi with a scoreboard of expected ranges.
module tb_led_control_multi;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [11:0] mode  = '0;
   logic [3:0]  ev    = '0;
   logic [3:0]  led;

   led_control_multi #(
      .CLOCK_SPEED  (1000),
      .CHANNELS     (4),
      .ACTIVE_LOW   (1'b1),
      .STRETCH_TICKS(10)
   ) dut (
      .i_clock  (clk),
      .i_reset_n(rst_n),
      .i_mode   (mode),
      .i_event  (ev),
      .o_led    (led)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      string tag;
      int    lo;
      int    hi;
   } exp_t;

   exp_t sb[$];
   int   n_pass = 0;
   int   n_tot  = 0;
   int   tq[4][$];

   task automatic expect_rng(input string tag, input int lo, input int hi);
      exp_t e;
      e.tag = tag;
      e.lo  = lo;
      e.hi  = hi;
      sb.push_back(e);
   endtask

   task automatic check(input int obs);
      exp_t e;
      n_tot++;
      if (sb.size() == 0) begin
         $error("FAIL sb_empty: observed %0d required no pending entry", obs);
      end else begin
         e = sb.pop_front();
         assert (obs >= e.lo && obs <= e.hi) n_pass++;
         else $error("FAIL %s: observed %0d required %0d..%0d",
                     e.tag, obs, e.lo, e.hi);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic record(input int n);
      logic [3:0] prev;
      for (int c = 0; c < 4; c++) tq[c].delete();
      prev = led;
      repeat (n) begin
         tick(1);
         for (int c = 0; c < 4; c++)
            if (led[c] !== prev[c]) tq[c].push_back(cyc);
         prev = led;
      end
   endtask

   function automatic int at(input int c, input int i);
      if (i < tq[c].size()) return tq[c][i];
      return -1000000 * (c + 1) - 1000 * i;
   endfunction

   task automatic wait_change(input int ch, input int maxc, output int t);
      logic v;
      v = led[ch];
      t = -1000000;
      for (int n = 0; n < maxc; n++) begin
         tick(1);
         if (led[ch] !== v) begin
            t = cyc;
            break;
         end
      end
   endtask

   initial begin
      int bad;
      int t0;
      int t;
      int te;
      int tr;

      tick(3);
      expect_rng("reset_dark", 15, 15);
      check(int'(led));

      rst_n = 1'b1;
      expect_rng("idle_dark_2000", 0, 0);
      bad = 0;
      repeat (2000) begin
         tick(1);
         if (led !== 4'hF) bad++;
      end
      check(bad);

      mode[2:0] = 3'd1;
      expect_rng("on_latency", 0, 0);
      tick(1);
      check(int'(led[0]));
      mode[2:0] = 3'd0;
      expect_rng("off_latency", 1, 1);
      tick(1);
      check(int'(led[0]));

      // slow on ch1 and fast on ch2 entered together
      mode[5:3] = 3'd2;
      mode[8:6] = 3'd3;
      t0 = cyc + 1;
      expect_rng("fast_first", 91, 100);
      for (int k = 1; k <= 4; k++) expect_rng("fast_period", 100, 100);
      expect_rng("slow_first", 491, 500);
      expect_rng("slow_period", 500, 500);
      expect_rng("align_first", 0, 0);
      expect_rng("align_second", 0, 0);
      record(1100);
      check(at(2, 0) - t0);
      for (int k = 1; k <= 4; k++) check(at(2, k) - at(2, k - 1));
      check(at(1, 0) - t0);
      check(at(1, 1) - at(1, 0));
      check(at(1, 0) - at(2, 4));
      check(at(1, 1) - at(2, 9));
      mode = '0;
      tick(2);

      mode[11:9] = 3'd4;
      t0 = cyc + 1;
      expect_rng("vary_i0", 491, 500);
      expect_rng("vary_i1", 500, 500);
      expect_rng("vary_i2", 100, 100);
      expect_rng("vary_i3", 100, 100);
      expect_rng("vary_i4", 500, 500);
      record(1800);
      check(at(3, 0) - t0);
      for (int k = 1; k <= 4; k++) check(at(3, k) - at(3, k - 1));
      mode = '0;
      tick(2);

      mode[8:6]  = 3'd1;
      mode[11:9] = 3'd1;
      tick(2);
      mode[8:6]  = 3'd7;
      mode[11:9] = 3'd6;
      expect_rng("mode7_dark", 1, 1);
      expect_rng("mode6_dark", 1, 1);
      tick(1);
      check(int'(led[2]));
      check(int'(led[3]));
      mode = '0;
      tick(2);

      ev[1] = 1'b1;
      expect_rng("event_ignored", 1, 1);
      tick(1);
      ev[1] = 1'b0;
      tick(1);
      check(int'(led[1]));

      mode[2:0] = 3'd5;
      tick(3);
      expect_rng("pulse_idle_dark", 1, 1);
      check(int'(led[0]));
      ev[0] = 1'b1;
      te = cyc + 1;
      expect_rng("pulse_lit", 0, 0);
      expect_rng("pulse_len", 91, 100);
      tick(1);
      ev[0] = 1'b0;
      check(int'(led[0]));
      wait_change(0, 200, t);
      check(t - te);

      tick(5);
      ev[0] = 1'b1;
      tick(1);
      ev[0] = 1'b0;
      tick(49);
      ev[0] = 1'b1;
      tick(1);
      ev[0] = 1'b0;
      te = cyc;
      expect_rng("retrig_extends", 0, 0);
      expect_rng("retrig_len", 91, 100);
      tick(50);
      check(int'(led[0]));
      wait_change(0, 100, t);
      check(t - te);

      mode = '0;
      mode[8:6] = 3'd3;
      tick(250);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      expect_rng("async_reset_dark", 15, 15);
      check(int'(led));
      tick(3);
      rst_n = 1'b1;
      tr = cyc;
      expect_rng("reset_fast_first", 99, 101);
      wait_change(2, 150, t);
      check(t - tr);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
